icache_responder: RTL and testbench

- Read-only, direct-mapped instruction cache. It is the responder end of the fetch stage's imem request interface (imem_read / imem_address in, imem_rdata / imem_resp out).
- It serves hits from a local line array.
- It fills misses from a 256-bit-line physical memory port (pmem).
- It sits between the IF stage and the instruction-side memory/arbiter.

---
 rtl/icache_responder_if.sv | 19 +
 rtl/icache_responder.sv | 87 ++++++++
 tb/tb_icache_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_responder_if.sv
// icache_responder_if: fetch request/response channel plus the line-fill memory port
interface icache_responder_if;
  logic         imem_read;
  logic [31:0]  imem_address;
  logic [31:0]  imem_rdata;
  logic         imem_resp;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  modport master (
    output imem_read, imem_address, pmem_rdata, pmem_resp,
    input  imem_rdata, imem_resp, pmem_read, pmem_address
  );
  modport slave (
    input  imem_read, imem_address, pmem_rdata, pmem_resp,
    output imem_rdata, imem_resp, pmem_read, pmem_address
  );
endinterface

// File: rtl/icache_responder.sv
// icache_responder: read-only direct-mapped instruction cache, 0-cycle hits, 256-bit line fills (ICACHE_PERF_CTR_EN adds hit/miss counters)
module icache_responder #(
  parameter int S_INDEX = 3
) (
  input  logic                clk,
  input  logic                rst,
  icache_responder_if.slave   bus
`ifdef ICACHE_PERF_CTR_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);
  localparam int LINE_BITS = 256;
  localparam int SETS      = 1 << S_INDEX;
  localparam int TAG_W     = 27 - S_INDEX;
  typedef enum logic {IDLE, FILL} state_t;
  state_t               r_state;
  logic [SETS-1:0]      r_valid;
  logic [TAG_W-1:0]     r_tag [SETS];
  logic [LINE_BITS-1:0] r_line [SETS];
  logic [26:0]          r_line_addr;
  logic                 r_pmem_read;
  logic [S_INDEX-1:0]   w_index;
  logic [S_INDEX-1:0]   w_fill_index;
  logic [TAG_W-1:0]     w_tag;
  logic [2:0]           w_offset;
  logic [LINE_BITS-1:0] w_line;
  logic                 w_hit;
  logic                 w_miss;
  logic                 w_fill_done;
  logic                 w_unused;
  assign w_index      = bus.imem_address[4+S_INDEX:5];
  assign w_tag        = bus.imem_address[31:5+S_INDEX];
  assign w_offset     = bus.imem_address[4:2];
  assign w_fill_index = r_line_addr[S_INDEX-1:0];
  assign w_line       = r_line[w_index];
  assign w_unused     = &{1'b0, bus.imem_address[1:0]};
  assign w_hit        = r_state == IDLE && bus.imem_read && r_valid[w_index] && r_tag[w_index] == w_tag;
  assign w_miss       = r_state == IDLE && bus.imem_read && !w_hit;
  assign w_fill_done  = r_state == FILL && bus.pmem_resp;
  assign bus.imem_resp    = w_hit;
  assign bus.imem_rdata   = w_hit ? w_line[{w_offset, 5'b0} +: 32] : '0;
  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_address = r_state == FILL ? {r_line_addr, 5'b0} : '0;
  // control FSM: a miss latches the line address and requests a fill; the fill response validates the set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pmem_read <= 1'b0;
      r_line_addr <= '0;
      r_valid     <= '0;
    end else if (w_miss) begin
      r_state     <= FILL;
      r_pmem_read <= 1'b1;
      r_line_addr <= bus.imem_address[31:5];
    end else if (w_fill_done) begin
      r_state                <= IDLE;
      r_pmem_read            <= 1'b0;
      r_valid[w_fill_index]  <= 1'b1;
    end
  end
  // tag and data arrays need no reset; they are meaningless until the set is valid
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_fill_index]  <= r_line_addr[26:S_INDEX];
      r_line[w_fill_index] <= bus.pmem_rdata;
    end
  end
`ifdef ICACHE_PERF_CTR_EN
  logic r_post_fill;
  logic w_post_fill_hit;
  assign w_post_fill_hit = r_post_fill && bus.imem_address[31:5] == r_line_addr;
  // counters: the first IDLE cycle after a fill re-serves the request that missed, so it is not a new hit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_post_fill <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      r_post_fill <= w_fill_done;
      if (w_hit && !w_post_fill_hit) hit_count <= hit_count + 32'd1;
      if (w_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed scenarios for the instruction cache with inline expected values
module tb_icache_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  icache_responder_if bus();
`ifdef ICACHE_PERF_CTR_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif
  icache_responder #(.S_INDEX(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_PERF_CTR_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [255:0] mk_line(input logic [31:0] base);
    for (int k = 0; k < 8; k++) mk_line[k*32 +: 32] = base + 32'(k);
  endfunction
  task automatic test_reset();
    bus.imem_read = 1'b1;
    bus.imem_address = 32'h64;
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    @(negedge clk); #1;
    vectors++;
    if ({bus.imem_resp, bus.pmem_read} !== 2'b00 || bus.imem_rdata !== 32'h0 || bus.pmem_address !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: resp=%b pmem_read=%b rdata=%h paddr=%h, want all zero", bus.imem_resp, bus.pmem_read, bus.imem_rdata, bus.pmem_address);
    end
    @(negedge clk);
    bus.imem_read = 1'b0;
    rst = 1'b1;
  endtask
  task automatic test_cold_miss();
    @(negedge clk);
    bus.imem_read = 1'b1;
    bus.imem_address = 32'h64;
    #1;
    vectors++;
    if ({bus.imem_resp, bus.pmem_read} !== 2'b00) begin
      miscompares++;
      $display("FAIL cold_miss_first: resp,pmem_read=%b want 00", {bus.imem_resp, bus.pmem_read});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = mk_line(32'hA000_0000);
      end
      #1;
      vectors++;
      if ({bus.imem_resp, bus.pmem_read} !== 2'b01 || bus.pmem_address !== 32'h60) begin
        miscompares++;
        $display("FAIL cold_miss_fill[%0d]: resp=%b pmem_read=%b paddr=%h want 0 1 00000060", c, bus.imem_resp, bus.pmem_read, bus.pmem_address);
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    vectors++;
    if ({bus.imem_resp, bus.pmem_read} !== 2'b10 || bus.imem_rdata !== 32'hA000_0001) begin
      miscompares++;
      $display("FAIL cold_miss_resp: resp=%b pmem_read=%b rdata=%h want 1 0 a0000001", bus.imem_resp, bus.pmem_read, bus.imem_rdata);
    end
  endtask
  task automatic test_hit_stream();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.imem_address = 32'h60 + 32'(4 * k);
      #1;
      vectors++;
      if ({bus.imem_resp, bus.pmem_read} !== 2'b10 || bus.imem_rdata !== 32'hA000_0000 + 32'(k)) begin
        miscompares++;
        $display("FAIL hit_stream[%0d]: resp=%b pmem_read=%b rdata=%h want 1 0 %h", k, bus.imem_resp, bus.pmem_read, bus.imem_rdata, 32'hA000_0000 + 32'(k));
      end
    end
  endtask
`ifdef ICACHE_PERF_CTR_EN
  task automatic test_perf_counters();
    @(negedge clk);
    bus.imem_read = 1'b0;
    #1;
    vectors++;
    if (miss_count !== 32'd1 || hit_count !== 32'd8) begin
      miscompares++;
      $display("FAIL perf_counters: miss=%0d hit=%0d want miss=1 hit=8", miss_count, hit_count);
    end
  endtask
`endif
  task automatic test_conflict();
    @(negedge clk);
    bus.imem_read = 1'b1;
    bus.imem_address = 32'h160;
    #1;
    vectors++;
    if (bus.imem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_miss: resp=%b want 0", bus.imem_resp);
    end
    @(negedge clk); #1;
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h160) begin
      miscompares++;
      $display("FAIL conflict_fill_addr: pmem_read=%b paddr=%h want 1 00000160", bus.pmem_read, bus.pmem_address);
    end
    @(negedge clk);
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = mk_line(32'hB000_0000);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    vectors++;
    if (bus.imem_resp !== 1'b1 || bus.imem_rdata !== 32'hB000_0000) begin
      miscompares++;
      $display("FAIL conflict_resp: resp=%b rdata=%h want 1 b0000000", bus.imem_resp, bus.imem_rdata);
    end
    @(negedge clk);
    bus.imem_address = 32'h60;
    #1;
    vectors++;
    if (bus.imem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_evicted: resp=%b want 0", bus.imem_resp);
    end
    @(negedge clk); #1;
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h60) begin
      miscompares++;
      $display("FAIL conflict_refill_addr: pmem_read=%b paddr=%h want 1 00000060", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = mk_line(32'hA000_0000);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    vectors++;
    if (bus.imem_resp !== 1'b1 || bus.imem_rdata !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL conflict_refill_resp: resp=%b rdata=%h want 1 a0000000", bus.imem_resp, bus.imem_rdata);
    end
  endtask
  task automatic test_abandon();
    @(negedge clk);
    bus.imem_address = 32'h200;
    #1;
    vectors++;
    if (bus.imem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL abandon_miss: resp=%b want 0", bus.imem_resp);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) bus.imem_read = 1'b0;
      if (c == 3) begin
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = mk_line(32'hC000_0000);
      end
      #1;
      vectors++;
      if ({bus.imem_resp, bus.pmem_read} !== 2'b01 || bus.pmem_address !== 32'h200) begin
        miscompares++;
        $display("FAIL abandon_fill[%0d]: resp=%b pmem_read=%b paddr=%h want 0 1 00000200", c, bus.imem_resp, bus.pmem_read, bus.pmem_address);
      end
    end
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1;
    vectors++;
    if ({bus.imem_resp, bus.pmem_read} !== 2'b00 || bus.imem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL abandon_no_resp: resp=%b pmem_read=%b rdata=%h want 0 0 0", bus.imem_resp, bus.pmem_read, bus.imem_rdata);
    end
    @(negedge clk);
    bus.imem_read = 1'b1;
    bus.imem_address = 32'h204;
    #1;
    vectors++;
    if ({bus.imem_resp, bus.pmem_read} !== 2'b10 || bus.imem_rdata !== 32'hC000_0001) begin
      miscompares++;
      $display("FAIL abandon_installed: resp=%b pmem_read=%b rdata=%h want 1 0 c0000001", bus.imem_resp, bus.pmem_read, bus.imem_rdata);
    end
  endtask
  task automatic test_idle_pmem_resp();
    @(negedge clk);
    bus.imem_read = 1'b0;
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = mk_line(32'hDEAD_0000);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.imem_read = 1'b1;
    bus.imem_address = 32'h68;
    #1;
    vectors++;
    if ({bus.imem_resp, bus.pmem_read} !== 2'b10 || bus.imem_rdata !== 32'hA000_0002) begin
      miscompares++;
      $display("FAIL idle_pmem_resp: resp=%b pmem_read=%b rdata=%h want 1 0 a0000002", bus.imem_resp, bus.pmem_read, bus.imem_rdata);
    end
  endtask
  task automatic test_async_reset();
    @(negedge clk);
    bus.imem_address = 32'h300;
    @(negedge clk); #1;
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h300) begin
      miscompares++;
      $display("FAIL areset_fill1: pmem_read=%b paddr=%h want 1 00000300", bus.pmem_read, bus.pmem_address);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.imem_resp, bus.pmem_read} !== 2'b00 || bus.pmem_address !== 32'h0) begin
      miscompares++;
      $display("FAIL areset_drop: resp=%b pmem_read=%b paddr=%h want 0 0 0", bus.imem_resp, bus.pmem_read, bus.pmem_address);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.imem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_remiss: resp=%b want 0", bus.imem_resp);
    end
    @(negedge clk); #1;
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h300) begin
      miscompares++;
      $display("FAIL areset_refill_addr: pmem_read=%b paddr=%h want 1 00000300", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = mk_line(32'hE000_0000);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.imem_address = 32'h60;
    #1;
    vectors++;
    if (bus.imem_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_valid_cleared: resp=%b want 0", bus.imem_resp);
    end
    @(negedge clk); #1;
    vectors++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h60) begin
      miscompares++;
      $display("FAIL areset_line60_refill: pmem_read=%b paddr=%h want 1 00000060", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = mk_line(32'hA000_0000);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    bus.imem_address = 32'h300;
    #1;
    vectors++;
    if (bus.imem_resp !== 1'b1 || bus.imem_rdata !== 32'hE000_0000) begin
      miscompares++;
      $display("FAIL areset_line300_kept: resp=%b rdata=%h want 1 e0000000", bus.imem_resp, bus.imem_rdata);
    end
    @(negedge clk);
    bus.imem_read = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stream();
`ifdef ICACHE_PERF_CTR_EN
    test_perf_counters();
`endif
    test_conflict();
    test_abandon();
    test_idle_pmem_resp();
    test_async_reset();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
